// File: rtl/loop_kernel_mt.sv
// Multi-token counting-loop kernel: up to SLOTS tokens iterate v <= v+STEP while cmp(v, BOUND) holds.
// Optional per-token recirculation counter on outs_iters: define LOOP_KERNEL_ITER_COUNT_EN.
module loop_kernel_mt #(
  parameter int DATA_TYPE = 10,
  parameter int BOUND     = 5,
  parameter int STEP      = 1,
  parameter int CMP_MODE  = 0,
  parameter int SLOTS     = 2,
  parameter int ITER_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] ins,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  output logic [DATA_TYPE-1:0] outs,
  output logic                 outs_valid,
  input  logic                 outs_ready
`ifdef LOOP_KERNEL_ITER_COUNT_EN
  ,
  output logic [ITER_W-1:0]    outs_iters
`endif
);

  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef logic [DATA_TYPE-1:0] data_t;
  typedef logic [IDX_W-1:0]     idx_t;

  localparam data_t BOUND_T = data_t'(BOUND);
  localparam data_t STEP_T  = data_t'(STEP);

  logic [SLOTS-1:0] slot_valid;
  data_t            slot_data [SLOTS];
  idx_t             rr;

  logic  sel_found, free_found;
  idx_t  sel_idx, free_idx, rr_nxt;
  int    scan_idx;
  data_t sel_data, sel_nxt;
  logic  sel_cont, exit_free, do_exit, do_recirc, admit;

  function automatic logic cont_pred(input data_t v);
    case (CMP_MODE)
      0:       cont_pred = (v < BOUND_T);
      1:       cont_pred = ($signed(v) < $signed(BOUND_T));
      2:       cont_pred = (v != BOUND_T);
      default: cont_pred = (v <= BOUND_T);
    endcase
  endfunction

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = 0;
    for (int i = 0; i < SLOTS; i++) begin
      scan_idx = (int'(rr) + i) % SLOTS;
      if (!sel_found && slot_valid[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx_t'(scan_idx);
      end
    end
  end

  // Lowest-index free slot; scanning downward lets the lowest one win.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!slot_valid[i]) begin
        free_found = 1'b1;
        free_idx   = idx_t'(i);
      end
    end
  end

  assign ins_ready = free_found;
  assign admit     = ins_valid & free_found;

  assign sel_data  = slot_data[sel_idx];
  assign sel_cont  = cont_pred(sel_data);
  assign sel_nxt   = sel_data + STEP_T;
  assign exit_free = ~outs_valid | outs_ready;
  assign do_recirc = sel_found & sel_cont;
  assign do_exit   = sel_found & ~sel_cont & exit_free;
  assign rr_nxt    = (sel_idx == idx_t'(SLOTS - 1)) ? '0 : sel_idx + idx_t'(1);

  // NOTE: sequential state uses non-blocking assignments so every process sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid <= '0;
      rr         <= '0;
    end else begin
      if (sel_found) rr <= rr_nxt;
      if (do_exit)   slot_valid[sel_idx]  <= 1'b0;
      if (admit)     slot_valid[free_idx] <= 1'b1;
    end
  end

  // NOTE: slot payloads are not reset; the valid bits alone decide whether a slot holds a token.
  always_ff @(posedge clk) begin
    if (do_recirc) slot_data[sel_idx]  <= sel_nxt;
    if (admit)     slot_data[free_idx] <= ins;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outs_valid <= 1'b0;
      outs       <= '0;
    end else if (do_exit) begin
      outs_valid <= 1'b1;
      outs       <= sel_nxt;
    end else if (outs_ready) begin
      outs_valid <= 1'b0;
    end
  end

`ifdef LOOP_KERNEL_ITER_COUNT_EN
  logic [ITER_W-1:0] slot_iters [SLOTS];

  always_ff @(posedge clk) begin
    if (do_recirc && (slot_iters[sel_idx] != '1))
      slot_iters[sel_idx] <= slot_iters[sel_idx] + 1'b1;
    if (admit) slot_iters[free_idx] <= '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         outs_iters <= '0;
    else if (do_exit) outs_iters <= slot_iters[sel_idx];
  end
`endif

endmodule

// File: tb/tb_loop_kernel_mt.sv
// Directed self-checking bench for loop_kernel_mt; iteration counts are checked when
// LOOP_KERNEL_ITER_COUNT_EN is defined.
module tb_loop_kernel_mt;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Main instance: default parameters.
  logic [9:0] ins = '0;
  logic       ins_valid = 1'b0;
  logic       ins_ready;
  logic [9:0] outs;
  logic       outs_valid;
  logic       outs_ready = 1'b1;
  logic [7:0] outs_iters;

  // Auxiliary instances: 0 = wrap case, 1 = signed compare, 2 = unsigned compare.
  logic [9:0] aux_in [3];
  logic       aux_vld [3];
  logic [3:0] a0_outs;
  logic [9:0] a1_outs, a2_outs;
  logic       a0_ov, a1_ov, a2_ov, a0_ir, a1_ir, a2_ir;
  logic [7:0] a0_it, a1_it, a2_it;

  loop_kernel_mt dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready)
`ifdef LOOP_KERNEL_ITER_COUNT_EN
    , .outs_iters(outs_iters)
`endif
  );

  loop_kernel_mt #(.DATA_TYPE(4), .BOUND(2), .STEP(3), .CMP_MODE(2)) dut_wrap (
    .clk(clk), .rst(rst), .ins(aux_in[0][3:0]), .ins_valid(aux_vld[0]), .ins_ready(a0_ir),
    .outs(a0_outs), .outs_valid(a0_ov), .outs_ready(1'b1)
`ifdef LOOP_KERNEL_ITER_COUNT_EN
    , .outs_iters(a0_it)
`endif
  );

  loop_kernel_mt #(.BOUND(2), .CMP_MODE(1)) dut_sgn (
    .clk(clk), .rst(rst), .ins(aux_in[1]), .ins_valid(aux_vld[1]), .ins_ready(a1_ir),
    .outs(a1_outs), .outs_valid(a1_ov), .outs_ready(1'b1)
`ifdef LOOP_KERNEL_ITER_COUNT_EN
    , .outs_iters(a1_it)
`endif
  );

  loop_kernel_mt #(.BOUND(2), .CMP_MODE(0)) dut_uns (
    .clk(clk), .rst(rst), .ins(aux_in[2]), .ins_valid(aux_vld[2]), .ins_ready(a2_ir),
    .outs(a2_outs), .outs_valid(a2_ov), .outs_ready(1'b1)
`ifdef LOOP_KERNEL_ITER_COUNT_EN
    , .outs_iters(a2_it)
`endif
  );

`ifndef LOOP_KERNEL_ITER_COUNT_EN
  assign outs_iters = '0;
  assign a0_it = '0;
  assign a1_it = '0;
  assign a2_it = '0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one token into the main instance, bounded wait on ins_ready.
  task automatic send(input logic [9:0] v, input string name);
    int budget = 50;
    ins = v;
    ins_valid = 1'b1;
    while (!ins_ready && budget > 0) begin
      step();
      budget--;
    end
    n_checks++;
    if (!ins_ready) begin
      n_errors++;
      $display("FAIL %s: ins_ready timeout, got %0b want 1", name, ins_ready);
    end
    step();
    ins_valid = 1'b0;
  endtask

  // Single token through the main instance with outs_ready=1; returns edges until outs_valid.
  task automatic run_main(input logic [9:0] v, output int lat, output logic [9:0] o,
                          output logic [7:0] it);
    lat = 0;
    ins = v;
    ins_valid = 1'b1;
    step();
    lat = 1;
    ins_valid = 1'b0;
    while (!outs_valid && lat < 100) begin
      step();
      lat++;
    end
    o  = outs;
    it = outs_iters;
  endtask

  task automatic run_aux(input int which, input logic [9:0] v, input logic [9:0] exp_o,
                         input logic [7:0] exp_it, input string name);
    int budget = 100;
    logic vld;
    logic [9:0] o;
    logic [7:0] it;
    aux_in[which] = v;
    aux_vld[which] = 1'b1;
    step();
    aux_vld[which] = 1'b0;
    vld = 1'b0;
    while (budget > 0) begin
      case (which)
        0:       begin vld = a0_ov; o = {6'd0, a0_outs}; it = a0_it; end
        1:       begin vld = a1_ov; o = a1_outs; it = a1_it; end
        default: begin vld = a2_ov; o = a2_outs; it = a2_it; end
      endcase
      if (vld) break;
      step();
      budget--;
    end
    n_checks++;
    if (!vld || o !== exp_o) begin
      n_errors++;
      $display("FAIL %s outs: got %0h (valid %0b) want %0h", name, o, vld, exp_o);
    end
`ifdef LOOP_KERNEL_ITER_COUNT_EN
    n_checks++;
    if (it !== exp_it) begin
      n_errors++;
      $display("FAIL %s iters: got %0d want %0d", name, it, exp_it);
    end
`endif
    step();
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (outs_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outs_valid: got %0b want 0", outs_valid);
    end
    step(); step();
    rst = 1'b1;
    step();
    n_checks++;
    if (outs !== 10'd0) begin
      n_errors++;
      $display("FAIL reset_outs: got %0h want 0", outs);
    end
    n_checks++;
    if (ins_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_ins_ready: got %0b want 1", ins_ready);
    end
`ifdef LOOP_KERNEL_ITER_COUNT_EN
    n_checks++;
    if (outs_iters !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_iters: got %0d want 0", outs_iters);
    end
`endif
  endtask

  task automatic test_single(input logic [9:0] v, input int exp_lat, input logic [9:0] exp_o,
                             input logic [7:0] exp_it, input string name);
    int lat;
    logic [9:0] o;
    logic [7:0] it;
    run_main(v, lat, o, it);
    n_checks++;
    if (lat !== exp_lat) begin
      n_errors++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (o !== exp_o) begin
      n_errors++;
      $display("FAIL %s outs: got %0h want %0h", name, o, exp_o);
    end
`ifdef LOOP_KERNEL_ITER_COUNT_EN
    n_checks++;
    if (it !== exp_it) begin
      n_errors++;
      $display("FAIL %s iters: got %0d want %0d", name, it, exp_it);
    end
`endif
    step();
  endtask

  task automatic test_backpressure();
    logic [9:0] held;
    int got6, got8, nout;
    outs_ready = 1'b0;
    send(10'd4, "bp_send4");
    send(10'd7, "bp_send7");
    n_checks++;
    if (ins_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_ready_drop: got %0b want 0", ins_ready);
    end
    repeat (10) step();
    n_checks++;
    if (outs_valid !== 1'b1 || (outs !== 10'd6 && outs !== 10'd8)) begin
      n_errors++;
      $display("FAIL bp_held: got valid %0b outs %0d want valid 1 outs 6 or 8", outs_valid, outs);
    end
    held = outs;
    repeat (3) step();
    n_checks++;
    if (outs !== held || outs_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_stable: got %0d valid %0b want %0d valid 1", outs, outs_valid, held);
    end
    outs_ready = 1'b1;
    got6 = 0; got8 = 0; nout = 0;
    for (int i = 0; i < 20; i++) begin
      if (outs_valid) begin
        nout++;
        if (outs == 10'd6) got6++;
        if (outs == 10'd8) got8++;
      end
      step();
    end
    n_checks++;
    if (nout !== 2 || got6 !== 1 || got8 !== 1) begin
      n_errors++;
      $display("FAIL bp_drain: got %0d outputs (6:%0d 8:%0d) want 2 (6:1 8:1)", nout, got6, got8);
    end
    n_checks++;
    if (ins_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_ready_back: got %0b want 1", ins_ready);
    end
    test_single(10'd1, 6, 10'd6, 8'd4, "bp_token1");
  endtask

  task automatic test_async_reset();
    int stale;
    int lat;
    logic [9:0] o;
    logic [7:0] it;
    outs_ready = 1'b0;
    send(10'd4, "ar_send4");
    send(10'd7, "ar_send7");
    send(10'd1, "ar_send1");
    repeat (6) step();
    n_checks++;
    if (outs_valid !== 1'b1 || ins_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL ar_pre: got valid %0b ready %0b want 1 0", outs_valid, ins_ready);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (outs_valid !== 1'b0 || outs !== 10'd0) begin
      n_errors++;
      $display("FAIL ar_async_clear: got valid %0b outs %0h want 0 0", outs_valid, outs);
    end
    step();
    @(negedge clk);
    rst = 1'b1;
    outs_ready = 1'b1;
    step();
    n_checks++;
    if (ins_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ar_ready: got %0b want 1", ins_ready);
    end
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      if (outs_valid) stale++;
      step();
    end
    n_checks++;
    if (stale !== 0) begin
      n_errors++;
      $display("FAIL ar_stale: got %0d stale outputs want 0", stale);
    end
    run_main(10'd0, lat, o, it);
    n_checks++;
    if (o !== 10'd6 || lat !== 7) begin
      n_errors++;
      $display("FAIL ar_fresh: got outs %0d lat %0d want 6 lat 7", o, lat);
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      aux_in[i]  = '0;
      aux_vld[i] = 1'b0;
    end
    test_reset();
    test_single(10'd0, 7, 10'd6, 8'd5, "loop_from0");
    test_single(10'd7, 2, 10'd8, 8'd0, "immediate_exit");
    test_single(10'd3, 4, 10'd6, 8'd2, "loop_from3");
    test_backpressure();
    run_aux(0, 10'd14, 10'd5, 8'd12, "wrap_ne");
    test_async_reset();
    run_aux(1, 10'h3FE, 10'd3, 8'd4, "signed_lt");
    run_aux(2, 10'h3FE, 10'h3FF, 8'd0, "unsigned_lt");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
